// File: rtl/mem_bist_seq.sv
// mem_bist_seq: built-in self-test sequencer for the 64 x 32-bit Mem block.
//
// On a rising edge of start it fills every word with a selectable pattern. It then
// reads every word back and counts mismatches. The result is reported as a pass/fail
// verdict, error statistics and a word for LedDisplay.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level request; its rising edge starts a run (ignored while busy)
//   pattern_sel       pattern select, latched on the accepted start edge
//   mem_w_en/addr/    registered write enable, address and write data towards Mem
//   mem_wdata
//   mem_rdata         read data from Mem, valid RD_LAT cycles after mem_addr
//   busy, done, pass  run status
//   err_count         number of mismatching words (saturates at 2^ADDR_W)
//   first_err_addr    address of the first mismatch of the run, 0 if none
//   disp_data         word for LedDisplay
module mem_bist_seq #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] disp_data
);

    localparam logic [ADDR_W-1:0] LastAddr  = '1;
    localparam logic [ADDR_W:0]   ErrMax    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]        DrainLast = 2'(RD_LAT);

    typedef enum logic [2:0] {StIdle, StFill, StRead, StDrain, StDone} state_e;

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] sel,
                                              input logic [ADDR_W-1:0] a);
        case (sel)
            2'b00:   pat = DATA_W'(32'h12345678);
            2'b01:   pat = DATA_W'(32'h87654321) ^ DATA_W'(a);
            2'b10:   pat = DATA_W'(1) << a[4:0];
            default: pat = ~DATA_W'(a);
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              start_q;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        drain_q, drain_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [DATA_W-1:0] last_rdata_q, last_rdata_d;
    logic              start_edge;
    logic              accept;
    logic              push;

    // Compare pipe: entry i is i+1 cycles behind mem_addr; the last stage lines up with
    // mem_rdata.
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
    logic [DATA_W-1:0] pipe_exp_q  [RD_LAT];
    logic              cmp_vld;
    logic              mismatch;

    assign start_edge = start & ~start_q;
    assign cmp_vld    = pipe_vld_q[RD_LAT-1];
    assign mismatch   = cmp_vld && (mem_rdata != pipe_exp_q[RD_LAT-1]);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        mem_w_en_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        accept      = 1'b0;
        push        = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_edge) begin
                    accept  = 1'b1;
                    sel_d   = pattern_sel;
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                mem_w_en_d  = 1'b1;
                mem_addr_d  = cnt_q;
                mem_wdata_d = pat(sel_q, cnt_q);
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                mem_addr_d = cnt_q;
                push       = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    drain_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // RD_LAT cycles to retire the last compare, one more to latch its result.
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_d        = err_q;
        first_d      = first_q;
        last_rdata_d = last_rdata_q;
        if (accept) begin
            err_d        = '0;
            first_d      = '0;
            last_rdata_d = '0;
        end else begin
            if (cmp_vld) begin
                last_rdata_d = mem_rdata;
            end
            if (mismatch) begin
                if (err_q == '0) begin
                    first_d = pipe_addr_q[RD_LAT-1];
                end
                if (err_q != ErrMax) begin
                    err_d = err_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            start_q      <= 1'b0;
            sel_q        <= '0;
            cnt_q        <= '0;
            drain_q      <= '0;
            mem_w_en_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= '0;
            first_q      <= '0;
            last_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            mem_w_en_q   <= mem_w_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            first_q      <= first_d;
            last_rdata_q <= last_rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else if (state_q == StIdle) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0]  <= push;
            pipe_addr_q[0] <= cnt_q;
            pipe_exp_q[0]  <= pat(sel_q, cnt_q);
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
            end
        end
    end

    always_comb begin
        disp_data = '0;
        case (state_q)
            StFill:          disp_data = mem_wdata_q;
            StRead, StDrain: disp_data = last_rdata_q;
            StDone:          disp_data = DATA_W'({9'b0, err_q, 10'b0, first_q});
            default:         disp_data = '0;
        endcase
    end

    assign mem_w_en       = mem_w_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign busy           = (state_q == StFill) || (state_q == StRead) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_bist_seq.sv
// Bench for mem_bist_seq: two instances (RD_LAT=1 and RD_LAT=2) are driven by the same
// start/pattern stimulus. Each has its own Mem model with a selectable read fault. Expected
// results come from the pattern formulas and the fault applied to every address.
module tb_mem_bist_seq;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int          DEPTH  = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [1:0] pattern_sel;

    always #5 clk = ~clk;

    logic              w_en   [2];
    logic [ADDR_W-1:0] addr   [2];
    logic [DATA_W-1:0] wdata  [2];
    logic [DATA_W-1:0] rdata  [2];
    logic              busy   [2];
    logic              done   [2];
    logic              pass   [2];
    logic [ADDR_W:0]   err    [2];
    logic [ADDR_W-1:0] ferr   [2];
    logic [DATA_W-1:0] disp   [2];

    mem_bist_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pattern_sel    (pattern_sel),
        .mem_w_en       (w_en[0]),
        .mem_addr       (addr[0]),
        .mem_wdata      (wdata[0]),
        .mem_rdata      (rdata[0]),
        .busy           (busy[0]),
        .done           (done[0]),
        .pass           (pass[0]),
        .err_count      (err[0]),
        .first_err_addr (ferr[0]),
        .disp_data      (disp[0])
    );

    mem_bist_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) u_dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pattern_sel    (pattern_sel),
        .mem_w_en       (w_en[1]),
        .mem_addr       (addr[1]),
        .mem_wdata      (wdata[1]),
        .mem_rdata      (rdata[1]),
        .busy           (busy[1]),
        .done           (done[1]),
        .pass           (pass[1]),
        .err_count      (err[1]),
        .first_err_addr (ferr[1]),
        .disp_data      (disp[1])
    );

    // Fault model: 0 none, 1 word fault_addr reads 0, 2 data bit 0 stuck at 0, 3 all inverted.
    int fault_mode;
    int fault_addr;

    function automatic logic [31:0] corrupt(int a, logic [31:0] d);
        case (fault_mode)
            1:       corrupt = (a == fault_addr) ? 32'h0 : d;
            2:       corrupt = d & 32'hFFFF_FFFE;
            3:       corrupt = ~d;
            default: corrupt = d;
        endcase
    endfunction

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [DATA_W-1:0] rd_q;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_en[i]) mem[i][addr[i]] <= wdata[i];
        end
        rd_q <= corrupt(int'(addr[1]), mem[1][addr[1]]);
    end

    assign rdata[0] = corrupt(int'(addr[0]), mem[0][addr[0]]);
    assign rdata[1] = rd_q;

    function automatic logic [31:0] ref_pat(int p, int a);
        case (p)
            0:       ref_pat = 32'h12345678;
            1:       ref_pat = 32'h87654321 ^ 32'(a);
            2:       ref_pat = 32'h1 << (a % 32);
            default: ref_pat = ~32'(a);
        endcase
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, exp);
        end
    endtask

    // One full run. start stays high for `hold` cycles counted from edge 0; `toggle` adds
    // an extra start edge during FILL, which must be ignored.
    task automatic run(input int p, input int fm, input int fa, input int hold, input bit toggle);
        int exp_err;
        int exp_first;
        logic [31:0] e;
        logic [31:0] exp_disp;
        int done_at [2];
        int wr_cnt  [2];
        int wr_bad  [2];
        fault_mode = fm;
        fault_addr = fa;
        exp_err   = 0;
        exp_first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            e = ref_pat(p, a);
            if (corrupt(a, e) != e) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        exp_disp = (32'(exp_err) << 16) | 32'(exp_first);

        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pattern_sel = 2'(p);
        start = 1'b1;
        @(posedge clk);  // edge 0
        for (int i = 0; i < 2; i++) begin
            done_at[i] = -1;
            wr_cnt[i]  = 0;
            wr_bad[i]  = 0;
        end
        for (int k = 1; k <= 140; k++) begin
            @(posedge clk);
            #1;
            if (k == hold) start = 1'b0;
            if (toggle && (k == 10 || k == 12)) start = ~start;
            if (k == 1) begin
                check("busy_after_start", 32'(busy[0]), 32'd1);
                check("err_cleared", 32'(err[0]), 32'd0);
            end
            for (int i = 0; i < 2; i++) begin
                if (w_en[i]) begin
                    wr_cnt[i]++;
                    if (int'(addr[i]) != k - 1 || wdata[i] != ref_pat(p, k - 1)) wr_bad[i]++;
                end
                if (done[i] && done_at[i] < 0) done_at[i] = k;
            end
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("done_cycle[%0d]", i), 32'(done_at[i]), 32'(130 + i));
            check($sformatf("wr_cnt[%0d]", i), 32'(wr_cnt[i]), 32'd64);
            check($sformatf("wr_bad[%0d]", i), 32'(wr_bad[i]), 32'd0);
            check($sformatf("err_count[%0d]", i), 32'(err[i]), 32'(exp_err));
            check($sformatf("first_err[%0d]", i), 32'(ferr[i]), 32'(exp_first));
            check($sformatf("pass[%0d]", i), 32'(pass[i]), 32'(exp_err == 0));
            check($sformatf("disp[%0d]", i), disp[i], exp_disp);
            check($sformatf("idle_after[%0d]", i), {30'b0, busy[i], done[i]}, 32'd1);
        end
    endtask

    task automatic reset_mid_run();
        fault_mode = 0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pattern_sel = 2'b00;
        start = 1'b1;
        @(posedge clk);  // edge 0
        repeat (70) @(posedge clk);
        #2;
        check("busy_before_rst", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_flags[%0d]", i), {28'b0, w_en[i], busy[i], done[i], pass[i]},
                  32'd0);
            check($sformatf("rst_addr[%0d]", i), 32'(addr[i]), 32'd0);
            check($sformatf("rst_wdata[%0d]", i), wdata[i], 32'd0);
            check($sformatf("rst_err[%0d]", i), {25'b0, err[i]} | 32'(ferr[i]), 32'd0);
            check($sformatf("rst_disp[%0d]", i), disp[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("stay_idle[%0d]", i), {29'b0, w_en[i], busy[i], done[i]}, 32'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        pattern_sel = 2'b00;
        fault_mode  = 0;
        fault_addr  = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_flags[%0d]", i), {28'b0, w_en[i], busy[i], done[i], pass[i]},
                  32'd0);
            check($sformatf("reset_addr[%0d]", i), 32'(addr[i]), 32'd0);
            check($sformatf("reset_wdata[%0d]", i), wdata[i], 32'd0);
            check($sformatf("reset_err[%0d]", i), 32'(err[i]), 32'd0);
            check($sformatf("reset_first[%0d]", i), 32'(ferr[i]), 32'd0);
            check($sformatf("reset_disp[%0d]", i), disp[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, 0, 1, 1'b0);      // clean memory, pattern 00
        run(2, 1, 5, 2, 1'b0);      // pattern 10, word 5 reads 0
        run(3, 2, 0, 1, 1'b0);      // pattern 11, bit 0 stuck at 0
        run(1, 3, 0, 3, 1'b0);      // pattern 01, every word wrong: saturation at 64
        run(0, 1, 7, 1000, 1'b1);   // start held through run plus an edge during FILL
        run(0, 0, 0, 1, 1'b0);      // restart from DONE clears the previous error
        reset_mid_run();
        run(2, 0, 0, 1, 1'b0);      // a normal run after the abandoned one
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 63)), int'($urandom_range(1, 5)),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bist_seq.md
# mem_bist_seq

Built-in self-test sequencer for the 64 x 32-bit `Mem` lab block. It sits directly upstream of `Mem` and drives its `w_en`, `addr` and `data_in`. On a start request it fills every word with a selectable pattern, reads every word back, and compares each read against the expected value. It exports a pass/fail verdict, error statistics and a 32-bit word for the existing `LedDisplay` stage.

## Interface
- `ADDR_W`, 6: memory address width; depth = 2^ADDR_W = 64.
- `DATA_W`, 32: memory word width.
- `RD_LAT`, 1: cycles from `mem_addr` registered to valid `mem_rdata`. Legal values are 1 or 2.

- `clk`  in  1: single clock; all state on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level input, synchronous to `clk` (debounced upstream). Its rising edge requests a run.
- `pattern_sel`  in  2: pattern select, sampled on the accepted start edge.
- `mem_w_en`  out  1: registered write enable to `Mem`.
- `mem_addr`  out  ADDR_W: registered address to `Mem`.
- `mem_wdata`  out  DATA_W: registered write data to `Mem`.
- `mem_rdata`  in  DATA_W: read data from `Mem`.
- `busy`  out  1: high in FILL, READ and DRAIN.
- `done`  out  1: high in DONE.
- `pass`  out  1: `done && err_count == 0`.
- `err_count`  out  ADDR_W+1: number of mismatching words, 0..64.
- `first_err_addr`  out  ADDR_W: address of the first mismatch; 0 if there is none.
- `disp_data`  out  DATA_W: word to drive `LedDisplay`.

## Operation
- Patterns are a function pat(a) of the word address a, using the latched select:
  - 00: 32'h12345678.
  - 01: 32'h87654321 ^ {26'b0, a}.
  - 10: 32'h1 << a[4:0].
  - 11: ~{26'b0, a}.
- FSM states: IDLE, FILL, READ, DRAIN, DONE.
  - IDLE: on a start rising edge, latch `pattern_sel`, clear `err_count`, `first_err_addr` and the address counter, then go to FILL.
  - FILL: for 64 cycles drive `mem_w_en`=1, `mem_addr`=a and `mem_wdata`=pat(a), with a = 0..63. After a=63 go to READ.
  - READ: for 64 cycles drive `mem_w_en`=0 and `mem_addr`=a, with a = 0..63. Push {valid, a, pat(a)} into an RD_LAT-deep compare pipe. After a=63 go to DRAIN.
  - DRAIN: run RD_LAT cycles so the last compares retire, then go to DONE.
  - DONE: outputs hold. A new start rising edge restarts the run exactly as from IDLE.
- Compare rule: when a pipe entry emerges valid and `mem_rdata` != expected, increment `err_count`. If this is the first mismatch of the run, latch its address into `first_err_addr`. `err_count` reaches 64 at most and never wraps.
- `disp_data` behaviour:
  - IDLE: 0.
  - FILL: `mem_wdata`.
  - READ and DRAIN: the most recently compared `mem_rdata`.
  - DONE: {9'b0, err_count, 10'b0, first_err_addr}.
- Start rising edges seen while `busy` are ignored. Edge detection uses a registered copy of `start`, so a held-high `start` triggers only once.
- The address counter is ADDR_W bits and wraps 63 -> 0 at each phase boundary. The phase change is decided on a==63 and never on overflow.

## Timing
- Reset values:
  - `mem_w_en`=0, `mem_addr`=0, `mem_wdata`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `first_err_addr`=0, `disp_data`=0.
  - State is IDLE and the start edge register is 0.
- Cycle 0 is the edge where `start` is first sampled high. At edge 1, the FILL address-0 write is presented (registered outputs); `Mem` writes it at edge 2.
- The first READ address is presented at edge 65 and the last at edge 128.
- The last compare happens at edge 128+RD_LAT. `done` rises at edge 129+RD_LAT (130 for RD_LAT=1).
- `mem_w_en` is high for exactly 64 consecutive cycles per run and never during READ.
- The compare pipe aligns the address and expected value exactly RD_LAT cycles behind `mem_addr`. The pipe valid bits clear on reset and in IDLE.
- An `rst_n` assertion mid-run asynchronously forces all reset values, including `mem_w_en`=0. The run is abandoned and the memory contents are undefined. There is no resume after reset.
- A start edge in the same cycle as the DONE entry is ignored, because the FSM is still `busy` in that cycle.

## Test plan
- Pattern 00, fault-free memory model with RD_LAT=1, start pulse:
  - `mem_w_en` high 64 cycles with addr 0..63 and data 32'h12345678.
  - `done` at cycle 130, `pass`=1, `err_count`=0, `disp_data`=32'h00000000.
- Pattern 10, model corrupting word 5 (reads 32'h0), RD_LAT=2:
  - `err_count`=1 and `first_err_addr`=5.
  - `disp_data`=32'h00010005 and `pass`=0.
- Pattern 11, model with stuck-at-0 data bit 0 (read data bit 0 forced to 0):
  - 32 mismatches (odd ~a values fail), first at addr 0.
  - `err_count`=32, `first_err_addr`=0, `disp_data`=32'h00200000.
- Start held high through an entire run, then toggled during FILL: only one run occurs. A new start edge in DONE restarts the run and clears `err_count`.
- `rst_n` pulsed low at cycle 70, mid-READ:
  - All outputs return to reset values within the same cycle, and `mem_w_en`=0.
  - The FSM stays in IDLE until the next start edge.
- Pattern 01, every word corrupted:
  - `err_count`=64, i.e. 7'h40 with no wrap.
  - `first_err_addr`=0 and `disp_data`=32'h00400000.
